// File: rtl/serial_full_adder.sv
// serial_full_adder
//   Bit-serial adder: one full-adder cell plus a carry flop, processing one
//   operand bit per clock, LSB first. {cout,sum} = a + b + cin (unsigned,
//   modulo 2^WIDTH with cout as bit WIDTH).
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN
//     When defined, adds output ovf = two's-complement signed overflow
//     (carry into MSB ^ carry out of MSB), held with sum.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   load request, only sampled in IDLE
//   a, b   in   [WIDTH-1:0] operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while bits are processed (RUN)
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  [WIDTH-1:0] result, held until next accepted start
//   cout   out  final carry, held with sum
//   ovf    out  (SERIAL_ADDER_OVF_EN only) signed overflow, held with sum
//
// Timing: accept at edge k, done high in the cycle after edge k+WIDTH,
// next accept possible at edge k+WIDTH+2.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s_bit, c_nx, last;

  // the single full-adder cell
  assign s_bit = a_sr[0] ^ b_sr[0] ^ c;
  assign c_nx  = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
  assign last  = (cnt == CW'(WIDTH - 1));

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      a_sr <= '0;
      b_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      // status flops track the state being entered so they align with it
      busy <= (state_nx == S_RUN);
      done <= (state_nx == S_DONE);
      case (state)
        S_IDLE: begin
          // sum is left alone here: old result stays visible one more cycle
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            c    <= cin;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          sum  <= {s_bit, sum[WIDTH-1:1]};
          c    <= c_nx;
          cnt  <= last ? '0 : cnt + CW'(1);
          // cout is a separate flop so reloading c with cin does not
          // disturb the held result
          if (last) begin
            cout <= c_nx;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= c ^ c_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder (WIDTH=8). Reference results come
// from plain integer arithmetic on the operands presented at accept time.
module tb_serial_full_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_full_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    ref_add = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
    int sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    s  = sx + sy + int'(ci);
    ref_ovf = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  // one complete operation from IDLE: accept, count busy, check result
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] e;
    int nbusy;
    bit got;
    e = ref_add(x, y, ci);
    start = 1'b1; a = x; b = y; cin = ci;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    nbusy = 0; got = 0;
    for (int i = 0; i < W + 4 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) nbusy++;
        tick();
      end
    end
    chk("busy_cycles", nbusy, W);
    chk("done_seen", 32'(got), 1);
    chk("busy_in_done", 32'(busy), 0);
    chk("sum", 32'(sum), 32'(e[W-1:0]));
    chk("cout", 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(ovf), 32'(ref_ovf(x, y, ci)));
`endif
    tick();
    chk("done_pulse_len", 32'(done), 0);
    chk("sum_held", 32'(sum), 32'(e[W-1:0]));
    chk("cout_held", 32'(cout), 32'(e[W]));
  endtask

  initial begin
    logic [W-1:0] qa [30];
    logic [W-1:0] qb [30];
    logic         qc [30];
    logic [W:0]   e;
    int           npulse;
    logic [W-1:0] cap_sum;
    logic         cap_cout;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    rst_n = 1'b1;
    tick();

    // directed operations
    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h40, 8'h20, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);

    // start re-asserted mid-run must be ignored
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'h01; b = 8'h01;
    tick(); tick(); tick();
    start = 1'b0;
    npulse = 0; cap_sum = '0; cap_cout = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        npulse++;
        cap_sum = sum;
        cap_cout = cout;
      end
      tick();
    end
    chk("ign_pulses", npulse, 1);
    chk("ign_sum", 32'(cap_sum), 32'h30);
    chk("ign_cout", 32'(cap_cout), 0);

    // reset mid-run discards the operation
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_sum", 32'(sum), 0);
    chk("mrst_cout", 32'(cout), 0);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) npulse++;
      tick();
    end
    chk("mrst_no_done", npulse, 0);
    run_op(8'h12, 8'h34, 1'b1);

    // start held high: accepts every W+2 cycles with the operands of that edge
    start = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      qa[cyc] = W'($urandom); qb[cyc] = W'($urandom); qc[cyc] = 1'($urandom);
      a = qa[cyc]; b = qb[cyc]; cin = qc[cyc];
      tick();
      chk("cont_busy", 32'(busy), 32'((cyc % (W + 2)) < W));
      chk("cont_done", 32'(done), 32'((cyc % (W + 2)) == W));
      if ((cyc % (W + 2)) == W) begin
        e = ref_add(qa[cyc - W], qb[cyc - W], qc[cyc - W]);
        chk("cont_sum", 32'(sum), 32'(e[W-1:0]));
        chk("cont_cout", 32'(cout), 32'(e[W]));
      end
    end
    start = 1'b0;
    tick(); tick();

    // random operations
    for (int n = 0; n < 20; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
- Bit-serial adder built around a single full-adder cell with a registered carry.
- Loads two WIDTH-bit operands plus carry-in, then processes one bit per clock, LSB first.
- Returns the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits downstream of operand sources and reuses the combinational full-adder function sequentially. It trades WIDTH cycles of latency for one adder cell.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request to load operands; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse: sum/cout valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  final carry; held with sum.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clk, reset port is rst_n.
- All outputs and state are registered.
- Reset (rst_n=0 at a rising edge of clk):
  - state=IDLE, bit counter=0, internal shift registers=0, carry register=0.
  - busy=0, done=0, sum=0, cout=0 (and ovf=0 when the optional feature is compiled in).
  - Reset wins over every other condition, including mid-RUN. A partial result is discarded and never signalled.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- IDLE -> RUN:
  - Occurs at an edge where start=1.
  - Captures a and b into shift registers, cin into the carry register, and clears the counter.
  - The sum register is not cleared until the first RUN edge, so the previous result stays visible for one cycle.
- RUN, each edge:
  - s = a0 ^ b0 ^ c; c_next = (a0&b0) | (c&(a0^b0)). Here a0/b0 are the current LSBs.
  - Shift the A/B registers right by one.
  - Shift s into the sum shift register MSB (shift right), so the LSB ends at bit 0 after WIDTH shifts.
  - counter++.
- RUN -> DONE:
  - Occurs at the edge that processes bit WIDTH-1 (counter == WIDTH-1).
  - sum and cout become final at that edge; cout = the carry out of bit WIDTH-1.
- DONE -> IDLE:
  - Occurs unconditionally on the next edge.
  - start in DONE is ignored and is not queued.
- start while busy=1 is ignored. Operand inputs may change freely after the accepting edge.
- Latency: accepting edge at cycle k; done=1 in the cycle after edge k+WIDTH. Next accept is possible at edge k+WIDTH+2. Throughput is one add per WIDTH+2 cycles.
- During RUN, sum shows a partial value; it is valid only while done=1 or in IDLE after done.
- Arithmetic is unsigned modulo 2^WIDTH, with cout as bit WIDTH: {cout,sum} = a + b + cin.
- The counter is wide enough for WIDTH-1. It never wraps inside a single operation.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output ovf (output, 1 bit), the two's-complement signed overflow.
  - ovf = carry into MSB XOR carry out of MSB, registered on the same edge as the final sum bit.
  - Held with sum; reset to 0.
- When undefined:
  - No ovf port exists and no extra logic is generated.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start for one cycle -> busy high for 8 cycles, then done pulse of exactly 1 cycle with sum=0x96, cout=0; values held afterwards.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start re-asserted with a=0x01, b=0x01 on cycles 3-5 of a running 0x10+0x20 operation -> ignored; result sum=0x30, cout=0; only one done pulse.
- rst_n=0 for one edge during RUN cycle 4 -> the next cycle has busy=0, done=0, sum=0, cout=0; no done pulse follows. A fresh start afterwards gives a correct result.
- start held high continuously with changing operands -> operations accepted at edges k, k+10, k+20 (WIDTH=8); each result matches the operands captured at its accepting edge.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=0x80, ovf=1; 0x80+0x80 -> sum=0x00, cout=1, ovf=1; 0x40+0x20 -> ovf=0.
